// File: rtl/adam_obi_pkg.sv
// Shared types and helpers for the OBI fixed-latency adapter slice.
// Types default to the 32-bit debug bus; clog2_depth sizes occupancy counters.
// Counters sized with clog2_depth can hold every value from 0 to depth inclusive.
package adam_obi_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] data_t;
  typedef logic [3:0]  strb_t;

  // Bits needed to hold any value 0..depth inclusive (at least one bit).
  function automatic int unsigned clog2_depth(input int unsigned depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/adam_obi_rsp_fifo.sv
// Response buffer: synchronous circular FIFO with push/pop, full/empty and occupancy count.
// Latency: a pushed entry is visible on rd_dat_o the cycle after the push; no bypass.
// Backpressure: pushes while full and pops while empty are ignored; the caller's credit rule prevents both.
// Ports: clk/rst_n; push_i/push_dat_i write side; pop_i read side; rd_dat_o head entry;
//        full_o/empty_o status; cnt_o current occupancy.
module adam_obi_rsp_fifo
  import adam_obi_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  parameter  int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = clog2_depth(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_dat_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rd_dat_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] cnt_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full_o   = (cnt_q == CNT_W'(DEPTH));
  assign empty_o  = (cnt_q == '0);
  assign cnt_o    = cnt_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; validity is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
  end

endmodule

// File: rtl/adam_obi_fixlat_adapter.sv
// Adapts a fixed-latency target (no gnt, rdata one cycle after req) to a handshaked OBI slave.
// Latency: grant is combinational with req; rvalid appears two cycles after the granting cycle.
// Backpressure: grants are credit-limited to RSP_DEPTH outstanding responses; a same-cycle pop returns one credit.
// Ports: clk/rst_n; upstream OBI req/gnt/addr/we/be/wdata and rvalid/rready/rdata;
//        target side mem_req/mem_we/mem_addr/mem_be/mem_wdata/mem_rdata.
// Optional macro ADAM_OBI_FIXLAT_PAUSE_EN adds pause_req/pause_ack: grants stop while
// pause_req is high and pause_ack reports (registered) that nothing is outstanding.
module adam_obi_fixlat_adapter
  import adam_obi_pkg::*;
#(
  parameter  int unsigned ADDR_WIDTH = 32,
  parameter  int unsigned DATA_WIDTH = 32,
  parameter  int unsigned RSP_DEPTH  = 2,
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req,
  output logic                  gnt,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  input  logic [STRB_WIDTH-1:0] be,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  rvalid,
  input  logic                  rready,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [STRB_WIDTH-1:0] mem_be,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef ADAM_OBI_FIXLAT_PAUSE_EN
  ,
  input  logic                  pause_req,
  output logic                  pause_ack
`endif
);

  localparam int unsigned CNT_W = clog2_depth(RSP_DEPTH);

  logic                  inflight_q;
  logic                  inflight_we_q;
  logic [CNT_W-1:0]      rsp_cnt;
  logic [CNT_W:0]        occ;
  logic                  pop;
  logic                  pause_blk;
  logic                  rsp_empty;
  logic                  unused_rsp_full;
  logic [DATA_WIDTH-1:0] push_dat;

  assign pop = rvalid && rready;

  // Outstanding = buffered responses plus the one whose data arrives next cycle.
  assign occ = {1'b0, rsp_cnt} + (CNT_W + 1)'(inflight_q);

  // A pop this cycle frees a slot before the newly granted response lands two cycles later.
  assign gnt = req && !pause_blk && ((occ < (CNT_W + 1)'(RSP_DEPTH)) || pop);

  assign mem_req   = req && gnt;
  assign mem_we    = we;
  assign mem_addr  = addr;
  assign mem_be    = be;
  assign mem_wdata = wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q    <= 1'b0;
      inflight_we_q <= 1'b0;
    end else begin
      inflight_q    <= mem_req;
      inflight_we_q <= mem_req && we;
    end
  end

  // Writes still produce one response so upstream ordering stays one-to-one.
  assign push_dat = inflight_we_q ? '0 : mem_rdata;

  adam_obi_rsp_fifo #(
    .DEPTH (RSP_DEPTH),
    .WIDTH (DATA_WIDTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_dat_i (push_dat),
    .pop_i      (pop),
    .rd_dat_o   (rdata),
    .full_o     (unused_rsp_full),
    .empty_o    (rsp_empty),
    .cnt_o      (rsp_cnt)
  );

  assign rvalid = !rsp_empty;

`ifdef ADAM_OBI_FIXLAT_PAUSE_EN
  logic pause_ack_q;

  assign pause_blk = pause_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pause_ack_q <= 1'b0;
    else        pause_ack_q <= pause_req && (occ == '0);
  end

  assign pause_ack = pause_ack_q;
`else
  assign pause_blk = 1'b0;
`endif

endmodule

// File: tb/tb_adam_obi_fixlat_adapter.sv
// Directed bench for adam_obi_fixlat_adapter with RSP_DEPTH=2.
// Target model returns 0xDEADBEEF at 0x1000, {16'hA000, addr[15:0]} elsewhere, junk outside the data cycle.
module tb_adam_obi_fixlat_adapter;

  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int SW    = DW / 8;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req;
  logic          gnt;
  logic [AW-1:0] addr;
  logic          we;
  logic [SW-1:0] be;
  logic [DW-1:0] wdata;
  logic          rvalid;
  logic          rready;
  logic [DW-1:0] rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [SW-1:0] mem_be;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
`ifdef ADAM_OBI_FIXLAT_PAUSE_EN
  logic          pause_req;
  logic          pause_ack;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  adam_obi_fixlat_adapter #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .RSP_DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .addr      (addr),
    .we        (we),
    .be        (be),
    .wdata     (wdata),
    .rvalid    (rvalid),
    .rready    (rready),
    .rdata     (rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
`ifdef ADAM_OBI_FIXLAT_PAUSE_EN
    ,
    .pause_req (pause_req),
    .pause_ack (pause_ack)
`endif
  );

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
    return {16'hA000, a[15:0]};
  endfunction

  // Fixed-latency target: read data valid only in the cycle after mem_req.
  always @(posedge clk) begin
    if (mem_req && !mem_we) mem_rdata <= model_rd(mem_addr);
    else                    mem_rdata <= 32'hBAD0_BAD0;
  end

  // The credit rule must keep the buffer from ever overflowing.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dut.u_rsp_fifo.cnt_o > 2'(DEPTH)) begin
        n_checks++;
        $display("FAIL rsp_cnt_bound: cnt=%0d limit=%0d", dut.u_rsp_fifo.cnt_o, DEPTH);
      end
      if (dut.u_rsp_fifo.push_i && dut.u_rsp_fifo.cnt_o == 2'(DEPTH)) begin
        n_checks++;
        $display("FAIL push_when_full: cnt=%0d at push", dut.u_rsp_fifo.cnt_o);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 1'b0; addr = '0; we = 1'b0; be = '0; wdata = '0; rready = 1'b0;
`ifdef ADAM_OBI_FIXLAT_PAUSE_EN
    pause_req = 1'b0;
`endif
    repeat (2) cyc();
    #3;
    n_checks++; if (gnt !== 1'b0)     $display("FAIL rst_gnt: got %b want 0", gnt);        else n_pass++;
    n_checks++; if (rvalid !== 1'b0)  $display("FAIL rst_rvalid: got %b want 0", rvalid);  else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rst_mem_req: got %b want 0", mem_req); else n_pass++;
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    cyc();
    req = 1'b1; addr = 32'h0000_1000; we = 1'b0; be = 4'hF; wdata = '0; rready = 1'b1;
    #3;
    n_checks++; if (gnt !== 1'b1)     $display("FAIL rd_gnt: got %b want 1", gnt);         else n_pass++;
    n_checks++; if (mem_req !== 1'b1) $display("FAIL rd_mem_req: got %b want 1", mem_req); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0000_1000) $display("FAIL rd_mem_addr: got %h want 00001000", mem_addr); else n_pass++;
    cyc(); req = 1'b0; #3;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL rd_rvalid_c1: got %b want 0", rvalid); else n_pass++;
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL rd_rvalid_c2: got %b want 1", rvalid); else n_pass++;
    n_checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL rd_rdata: got %h want deadbeef", rdata); else n_pass++;
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL rd_rvalid_c3: got %b want 0", rvalid); else n_pass++;
  endtask

  task automatic test_single_write();
    cyc();
    req = 1'b1; addr = 32'h0000_1004; we = 1'b1; be = 4'hF; wdata = 32'h1234_5678; rready = 1'b1;
    #3;
    n_checks++; if (gnt !== 1'b1)    $display("FAIL wr_gnt: got %b want 1", gnt);       else n_pass++;
    n_checks++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we: got %b want 1", mem_we); else n_pass++;
    n_checks++; if (mem_wdata !== 32'h1234_5678) $display("FAIL wr_mem_wdata: got %h want 12345678", mem_wdata); else n_pass++;
    n_checks++; if (mem_be !== 4'hF) $display("FAIL wr_mem_be: got %h want f", mem_be); else n_pass++;
    n_checks++; if (mem_addr !== 32'h0000_1004) $display("FAIL wr_mem_addr: got %h want 00001004", mem_addr); else n_pass++;
    cyc(); req = 1'b0; we = 1'b0; #3;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL wr_rvalid_c1: got %b want 0", rvalid); else n_pass++;
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL wr_rvalid_c2: got %b want 1", rvalid); else n_pass++;
    n_checks++; if (rdata !== 32'h0) $display("FAIL wr_rdata: got %h want 00000000", rdata); else n_pass++;
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL wr_rvalid_c3: got %b want 0", rvalid); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int k = 0;
    logic exp_v;
    for (int i = 0; i < 12; i++) begin
      cyc();
      rready = 1'b1; we = 1'b0;
      if (i < 8) begin
        req = 1'b1; addr = 32'h0000_2000 + 32'(4 * i);
      end else begin
        req = 1'b0;
      end
      #3;
      if (i < 8) begin
        n_checks++; if (gnt !== 1'b1) $display("FAIL b2b_gnt[%0d]: got %b want 1", i, gnt); else n_pass++;
      end
      exp_v = (i >= 2 && i < 10);
      n_checks++; if (rvalid !== exp_v) $display("FAIL b2b_rvalid[%0d]: got %b want %b", i, rvalid, exp_v); else n_pass++;
      if (rvalid && k < 8) begin
        n_checks++;
        if (rdata !== 32'hA000_2000 + 32'(4 * k)) $display("FAIL b2b_rdata[%0d]: got %h want %h", k, rdata, 32'hA000_2000 + 32'(4 * k));
        else n_pass++;
        k++;
      end
    end
    n_checks++; if (k != 8) $display("FAIL b2b_count: got %0d want 8", k); else n_pass++;
  endtask

  task automatic test_backpressure();
    int gcount = 0;
    logic exp_g;
    for (int i = 0; i < 5; i++) begin
      cyc();
      req = 1'b1; we = 1'b0; rready = 1'b0; addr = 32'h0000_3000 + 32'(4 * gcount);
      #3;
      exp_g = (i < 2);
      n_checks++; if (gnt !== exp_g) $display("FAIL bp_gnt[%0d]: got %b want %b", i, gnt, exp_g); else n_pass++;
      if (gnt) gcount++;
    end
    n_checks++; if (gcount != 2) $display("FAIL bp_grants: got %0d want 2", gcount); else n_pass++;
    cyc();
    req = 1'b1; addr = 32'h0000_3000 + 32'(4 * gcount); rready = 1'b1;
    #3;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL bp_rvalid_release: got %b want 1", rvalid); else n_pass++;
    n_checks++; if (gnt !== 1'b1)    $display("FAIL bp_gnt_release: got %b want 1", gnt);      else n_pass++;
    n_checks++; if (rdata !== 32'hA000_3000) $display("FAIL bp_rdata0: got %h want a0003000", rdata); else n_pass++;
    cyc(); req = 1'b0; #3;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL bp_rvalid1: got %b want 1", rvalid); else n_pass++;
    n_checks++; if (rdata !== 32'hA000_3004) $display("FAIL bp_rdata1: got %h want a0003004", rdata); else n_pass++;
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL bp_rvalid2: got %b want 1", rvalid); else n_pass++;
    n_checks++; if (rdata !== 32'hA000_3008) $display("FAIL bp_rdata2: got %h want a0003008", rdata); else n_pass++;
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL bp_drained: got %b want 0", rvalid); else n_pass++;
  endtask

  task automatic test_reset_mid();
    cyc();
    req = 1'b1; we = 1'b0; addr = 32'h0000_4000; rready = 1'b0;
    #3;
    n_checks++; if (gnt !== 1'b1) $display("FAIL rm_gnt0: got %b want 1", gnt); else n_pass++;
    cyc(); addr = 32'h0000_4004; #3;
    n_checks++; if (gnt !== 1'b1) $display("FAIL rm_gnt1: got %b want 1", gnt); else n_pass++;
    cyc(); req = 1'b0; #3;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL rm_buffered: got %b want 1", rvalid); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if (rvalid !== 1'b0)  $display("FAIL rm_rvalid_async: got %b want 0", rvalid);   else n_pass++;
    n_checks++; if (mem_req !== 1'b0) $display("FAIL rm_mem_req_async: got %b want 0", mem_req); else n_pass++;
    cyc();
    cyc(); rst_n = 1'b1; rready = 1'b1; #3;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL rm_no_stale: got %b want 0", rvalid); else n_pass++;
    cyc(); req = 1'b1; addr = 32'h0000_5000; #3;
    n_checks++; if (gnt !== 1'b1) $display("FAIL rm_gnt_fresh: got %b want 1", gnt); else n_pass++;
    cyc(); req = 1'b0; #3;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL rm_rvalid_c1: got %b want 0", rvalid); else n_pass++;
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL rm_rvalid_c2: got %b want 1", rvalid); else n_pass++;
    n_checks++; if (rdata !== 32'hA000_5000) $display("FAIL rm_rdata: got %h want a0005000", rdata); else n_pass++;
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b0) $display("FAIL rm_rvalid_c3: got %b want 0", rvalid); else n_pass++;
  endtask

`ifdef ADAM_OBI_FIXLAT_PAUSE_EN
  task automatic test_pause();
    // cycle:            2  3  4  5  6  7
    logic exp_ack [6] = '{0, 0, 0, 1, 1, 0};
    logic exp_gnt [6] = '{0, 0, 0, 0, 1, 0};
    cyc();
    req = 1'b1; we = 1'b0; addr = 32'h0000_6000; rready = 1'b0; pause_req = 1'b0;
    #3;
    n_checks++; if (gnt !== 1'b1) $display("FAIL pz_gnt0: got %b want 1", gnt); else n_pass++;
    cyc(); addr = 32'h0000_6004; #3;
    n_checks++; if (gnt !== 1'b1) $display("FAIL pz_gnt1: got %b want 1", gnt); else n_pass++;
    for (int i = 0; i < 6; i++) begin
      cyc();
      addr = 32'h0000_6008; rready = 1'b1;
      req = (i < 5);
      pause_req = (i < 4);
      #3;
      n_checks++; if (pause_ack !== exp_ack[i]) $display("FAIL pz_ack[c%0d]: got %b want %b", i + 2, pause_ack, exp_ack[i]); else n_pass++;
      n_checks++; if (gnt !== exp_gnt[i]) $display("FAIL pz_gnt[c%0d]: got %b want %b", i + 2, gnt, exp_gnt[i]); else n_pass++;
    end
    cyc(); #3;
    n_checks++; if (rvalid !== 1'b1) $display("FAIL pz_rvalid: got %b want 1", rvalid); else n_pass++;
    n_checks++; if (rdata !== 32'hA000_6008) $display("FAIL pz_rdata: got %h want a0006008", rdata); else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
`ifdef ADAM_OBI_FIXLAT_PAUSE_EN
    test_pause();
`endif
    repeat (3) cyc();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
